// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port instruction/data memory between the fetch port and
// the data port. One access is in flight at a time: the grant registers the
// winning request, the next cycle strobes mem_en, and the owner gets a
// one-cycle response MEM_LAT cycles after the strobe. The data port wins ties.
//
// Optional build macro: ARB_STARVE_GUARD_EN
//   When defined, a saturating 4-bit counter tracks data grants issued while
//   fetch is waiting. Once it reaches STARVE_MAX, fetch wins the next tie.
//
// state  | meaning
// IDLE   | no access in flight, grants may be issued
// ISSUE  | mem_en cycle with the registered request fields
// WAIT   | counting down MEM_LAT, response when counter reaches 1
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [DATA_W/8-1:0]   dm_be_i,
    input  logic [ADDR_W-1:0]     dm_addr_i,
    input  logic [DATA_W-1:0]     dm_wdata_i,
    output logic                  dm_gnt_o,
    output logic                  dm_rvalid_o,
    output logic [DATA_W-1:0]     dm_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  busy_o
);

    localparam int BE_W = DATA_W / 8;

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("unified_mem_arbiter: MEM_LAT must be within 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("unified_mem_arbiter: STARVE_MAX must be within 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                fetch_first;
    logic                resp_cyc;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign fetch_first = if_req_i && (starve_q == 4'(STARVE_MAX));

    // Count data grants that overtook a waiting fetch; cleared once fetch is served or gives up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= 4'd0;
        end else if (!if_req_i || if_gnt_o) begin
            starve_q <= 4'd0;
        end else if (dm_gnt_o && (starve_q != 4'hF)) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    assign fetch_first = 1'b0;
`endif

    // Grant decision: only in IDLE, data first unless the starvation guard hands the tie to fetch.
    always_comb begin
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        if (rst_ni && (state_q == ST_IDLE)) begin
            if (dm_req_i && !fetch_first) begin
                dm_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    // Next-state, latency counter and capture of the granted request.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dm_gnt_o) begin
                    state_d = ST_ISSUE;
                    owner_d = OWN_DM;
                    we_d    = dm_we_i;
                    be_d    = dm_be_i;
                    addr_d  = dm_addr_i;
                    wdata_d = dm_wdata_i;
                end else if (if_gnt_o) begin
                    state_d = ST_ISSUE;
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    be_d    = '1;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = 4'(MEM_LAT);
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_NONE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory strobe and response steering; data buses are zero whenever not valid.
    always_comb begin
        resp_cyc    = (state_q == ST_WAIT) && (cnt_q == 4'd1);
        if_rvalid_o = resp_cyc && (owner_q == OWN_IF);
        dm_rvalid_o = resp_cyc && (owner_q == OWN_DM);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = (dm_rvalid_o && !we_q) ? mem_rdata_i : '0;
        mem_en_o    = (state_q == ST_ISSUE);
        mem_we_o    = mem_en_o && we_q;
        mem_wdata_o = mem_en_o ? wdata_q : '0;
        mem_be_o    = be_q;
        mem_addr_o  = addr_q;
        busy_o      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a cycle-number model.
module tb_unified_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          dm_req_i, dm_we_i;
    logic [3:0]    dm_be_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_gnt_o, dm_rvalid_o;
    logic [DW-1:0] dm_rdata_o;
    logic          mem_en_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;

    int n_checks;
    int n_errors;

    always #5 clk_i = ~clk_i;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] rdata;
        logic        exp_if_gnt;
        logic        exp_dm_gnt;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_dm_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        if_req_i   = 1'b0;
        if_addr_i  = '0;
        dm_req_i   = 1'b0;
        dm_we_i    = 1'b0;
        dm_be_i    = '0;
        dm_addr_i  = '0;
        dm_wdata_i = '0;
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, ".if_gnt"},    32'(if_gnt_o),    32'd0);
        chk({p, ".if_rvalid"}, 32'(if_rvalid_o), 32'd0);
        chk({p, ".if_rdata"},  if_rdata_o,       32'd0);
        chk({p, ".dm_gnt"},    32'(dm_gnt_o),    32'd0);
        chk({p, ".dm_rvalid"}, 32'(dm_rvalid_o), 32'd0);
        chk({p, ".dm_rdata"},  dm_rdata_o,       32'd0);
        chk({p, ".mem_en"},    32'(mem_en_o),    32'd0);
        chk({p, ".mem_we"},    32'(mem_we_o),    32'd0);
        chk({p, ".mem_be"},    32'(mem_be_o),    32'd0);
        chk({p, ".mem_addr"},  mem_addr_o,       32'd0);
        chk({p, ".mem_wdata"}, mem_wdata_o,      32'd0);
        chk({p, ".busy"},      32'(busy_o),      32'd0);
    endtask

    // One complete transaction from an idle arbiter, cycle T through T+1+LAT.
    task automatic run_vec(input vec_t v, input string p);
        tick();
        if_req_i   = v.if_req;
        if_addr_i  = v.if_addr;
        dm_req_i   = v.dm_req;
        dm_we_i    = v.dm_we;
        dm_be_i    = v.dm_be;
        dm_addr_i  = v.dm_addr;
        dm_wdata_i = v.dm_wdata;
        mem_rdata_i = v.rdata;
        settle();
        chk({p, ".if_gnt"}, 32'(if_gnt_o), 32'(v.exp_if_gnt));
        chk({p, ".dm_gnt"}, 32'(dm_gnt_o), 32'(v.exp_dm_gnt));
        chk({p, ".busy_T"}, 32'(busy_o), 32'd0);
        tick();
        idle_inputs();
        settle();
        chk({p, ".mem_en"},    32'(mem_en_o), 32'd1);
        chk({p, ".mem_we"},    32'(mem_we_o), 32'(v.exp_we));
        chk({p, ".mem_be"},    32'(mem_be_o), 32'(v.exp_be));
        chk({p, ".mem_addr"},  mem_addr_o,    v.exp_addr);
        chk({p, ".mem_wdata"}, mem_wdata_o,   v.exp_wdata);
        chk({p, ".busy_T1"},   32'(busy_o),   32'd1);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            settle();
            if (k < LAT) begin
                chk({p, ".early_if_rvalid"}, 32'(if_rvalid_o), 32'd0);
                chk({p, ".early_dm_rvalid"}, 32'(dm_rvalid_o), 32'd0);
                chk({p, ".wait_mem_en"},     32'(mem_en_o),    32'd0);
            end else begin
                chk({p, ".if_rvalid"},  32'(if_rvalid_o), 32'(v.exp_if_gnt));
                chk({p, ".dm_rvalid"},  32'(dm_rvalid_o), 32'(v.exp_dm_gnt));
                chk({p, ".if_rdata"},   if_rdata_o,       v.exp_if_rdata);
                chk({p, ".dm_rdata"},   dm_rdata_o,       v.exp_dm_rdata);
                chk({p, ".mem_wdata0"}, mem_wdata_o,      32'd0);
                chk({p, ".addr_hold"},  mem_addr_o,       v.exp_addr);
                chk({p, ".busy_resp"},  32'(busy_o),      32'd1);
            end
        end
    endtask

    initial begin
        int free_at, resp_at, issue_at, starve;
        bit resp_if, resp_store, iss_we, prev_if_gnt, prev_dm_gnt;
        bit idle, e_dm, e_if, e_resp, e_en, fetch_pref;
        logic [3:0]  hold_be;
        logic [31:0] hold_addr, iss_wdata;

        n_checks = 0;
        n_errors = 0;
        rst_ni = 1'b0;
        idle_inputs();
        mem_rdata_i = '0;

        //          ifr  if_addr        dmr  we   be    dm_addr        dm_wdata       rdata          eif  edm  ewe  ebe   eaddr          ewdata         eif_rdata      edm_rdata
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0,         32'h0050_0093, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'h0050_0093, 32'h0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         32'h0};
        vecs[2] = '{1'b1, 32'h0000_0044, 1'b1, 1'b0, 4'h3, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 4'h3, 32'h0000_0200, 32'h0,         32'h0,         32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h0000_0048, 1'b1, 1'b1, 4'h6, 32'h0000_0300, 32'hA5A5_A5A5, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 4'h6, 32'h0000_0300, 32'hA5A5_A5A5, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 4'h5, 32'h0000_0500, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFF, 32'h0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0,         32'h0,         32'h0};

        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rst_ni = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: data first, fetch granted at T+LAT+2.
        tick();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h400;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        mem_rdata_i = 32'h1111_2222;
        settle();
        chk("s3.dm_gnt", 32'(dm_gnt_o), 32'd1);
        chk("s3.if_gnt", 32'(if_gnt_o), 32'd0);
        tick();
        dm_req_i = 1'b0;
        settle();
        chk("s3.if_gnt_T1", 32'(if_gnt_o), 32'd0);
        for (int k = 2; k <= LAT + 1; k++) begin
            tick();
            settle();
            chk($sformatf("s3.if_gnt_T%0d", k), 32'(if_gnt_o), 32'd0);
            if (k == LAT + 1) begin
                chk("s3.dm_rvalid", 32'(dm_rvalid_o), 32'd1);
                chk("s3.dm_rdata",  dm_rdata_o,       32'h1111_2222);
                chk("s3.if_rvalid_early", 32'(if_rvalid_o), 32'd0);
            end
        end
        tick();
        mem_rdata_i = 32'h3333_4444;
        settle();
        chk("s3.if_gnt_late", 32'(if_gnt_o), 32'd1);
        chk("s3.dm_gnt_late", 32'(dm_gnt_o), 32'd0);
        tick();
        idle_inputs();
        settle();
        chk("s3.mem_addr", mem_addr_o, 32'h20);
        repeat (LAT) begin
            tick();
            settle();
        end
        chk("s3.if_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("s3.if_rdata",  if_rdata_o,       32'h3333_4444);

        // Fetch arriving while a store is in flight is held off until IDLE.
        tick();
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hC; dm_addr_i = 32'h140; dm_wdata_i = 32'h0102_0304;
        mem_rdata_i = 32'h5555_AAAA;
        settle();
        chk("s4.dm_gnt", 32'(dm_gnt_o), 32'd1);
        tick();
        idle_inputs();
        if_req_i = 1'b1; if_addr_i = 32'h30;
        settle();
        chk("s4.if_gnt_T1", 32'(if_gnt_o), 32'd0);
        chk("s4.mem_wdata", mem_wdata_o, 32'h0102_0304);
        for (int k = 2; k <= LAT + 1; k++) begin
            tick();
            settle();
            chk($sformatf("s4.if_gnt_T%0d", k), 32'(if_gnt_o), 32'd0);
        end
        chk("s4.store_ack",   32'(dm_rvalid_o), 32'd1);
        chk("s4.store_rdata", dm_rdata_o,       32'd0);
        tick();
        settle();
        chk("s4.if_gnt_late", 32'(if_gnt_o), 32'd1);
        tick();
        idle_inputs();
        repeat (LAT) tick();

        // Reset during WAIT abandons the load.
        tick();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h80;
        mem_rdata_i = 32'hBAD0_BAD0;
        settle();
        chk("s5.dm_gnt", 32'(dm_gnt_o), 32'd1);
        tick();
        idle_inputs();
        tick();
        rst_ni = 1'b0;
        dm_req_i = 1'b1;
        #1;
        chk_all_zero("s5.rst");
        repeat (2) begin
            tick();
            settle();
            chk("s5.rst_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
            chk("s5.rst_dm_gnt",    32'(dm_gnt_o),    32'd0);
        end
        tick();
        dm_req_i = 1'b0;
        rst_ni = 1'b1;
        repeat (LAT + 1) begin
            settle();
            chk("s5.post_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
            chk("s5.post_busy",      32'(busy_o),      32'd0);
            tick();
        end
        run_vec(vecs[0], "s5.fetch");

        // Both requests held for ten transactions.
        tick();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h600;
        if_req_i = 1'b1; if_addr_i = 32'h60;
        settle();
        for (int t = 0; t < 10 * (LAT + 2); t++) begin
            if (t > 0) begin
                tick();
                settle();
            end
            if (t % (LAT + 2) == 0) begin
                bit exp_if;
                exp_if = GUARD && ((t / (LAT + 2)) % 5 == 4);
                chk($sformatf("s6.if_gnt_n%0d", t / (LAT + 2)), 32'(if_gnt_o), 32'(exp_if));
                chk($sformatf("s6.dm_gnt_n%0d", t / (LAT + 2)), 32'(dm_gnt_o), 32'(!exp_if));
            end else begin
                chk($sformatf("s6.no_gnt_t%0d", t), 32'(if_gnt_o | dm_gnt_o), 32'd0);
            end
        end
        tick();
        idle_inputs();

        // Randomized traffic against a transaction-timing model.
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        free_at = 0; resp_at = -1; issue_at = -1; starve = 0;
        resp_if = 1'b0; resp_store = 1'b0; iss_we = 1'b0;
        prev_if_gnt = 1'b0; prev_dm_gnt = 1'b0;
        hold_be = '0; hold_addr = '0; iss_wdata = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!if_req_i || prev_if_gnt) begin
                if_req_i  = ($urandom_range(0, 1) == 1);
                if_addr_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_i = 1'b0;
            end
            if (!dm_req_i || prev_dm_gnt) begin
                dm_req_i   = ($urandom_range(0, 1) == 1);
                dm_we_i    = ($urandom_range(0, 1) == 1);
                dm_be_i    = 4'($urandom_range(0, 15));
                dm_addr_i  = $urandom;
                dm_wdata_i = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dm_req_i = 1'b0;
            end
            mem_rdata_i = $urandom;
            settle();

            idle       = (c >= free_at);
            fetch_pref = GUARD && if_req_i && (starve == SMAX);
            e_dm       = idle && dm_req_i && !fetch_pref;
            e_if       = idle && if_req_i && !e_dm;
            e_resp     = (c == resp_at);
            e_en       = (c == issue_at);

            chk("rnd.if_gnt",    32'(if_gnt_o),    32'(e_if));
            chk("rnd.dm_gnt",    32'(dm_gnt_o),    32'(e_dm));
            chk("rnd.if_rvalid", 32'(if_rvalid_o), 32'(e_resp && resp_if));
            chk("rnd.dm_rvalid", 32'(dm_rvalid_o), 32'(e_resp && !resp_if));
            chk("rnd.if_rdata",  if_rdata_o, (e_resp && resp_if) ? mem_rdata_i : 32'd0);
            chk("rnd.dm_rdata",  dm_rdata_o, (e_resp && !resp_if && !resp_store) ? mem_rdata_i : 32'd0);
            chk("rnd.mem_en",    32'(mem_en_o),    32'(e_en));
            chk("rnd.mem_we",    32'(mem_we_o),    32'(e_en && iss_we));
            chk("rnd.mem_wdata", mem_wdata_o, e_en ? iss_wdata : 32'd0);
            chk("rnd.mem_addr",  mem_addr_o,  hold_addr);
            chk("rnd.mem_be",    32'(mem_be_o),    32'(hold_be));
            chk("rnd.busy",      32'(busy_o),      32'(!idle));

            if (e_dm || e_if) begin
                issue_at   = c + 1;
                resp_at    = c + 1 + LAT;
                free_at    = c + LAT + 2;
                resp_if    = e_if;
                resp_store = e_dm && dm_we_i;
                iss_we     = e_dm && dm_we_i;
                iss_wdata  = e_dm ? dm_wdata_i : 32'd0;
                hold_addr  = e_dm ? dm_addr_i : if_addr_i;
                hold_be    = e_dm ? dm_be_i : 4'hF;
            end
            if (!if_req_i || e_if) starve = 0;
            else if (e_dm && starve < 15) starve++;
            prev_if_gnt = e_if;
            prev_dm_gnt = e_dm;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF stage (fetch port) and the MEM stage (data port) of the five-stage pipelined core.
- Grants one requester at a time and issues its access to memory.
- Waits a fixed memory latency, then returns a one-cycle response to the owning requester.
- Core stalls IF or MEM while the relevant gnt/rvalid is pending.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid (1 cycle)
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held with fields until dm_gnt
dm_we  in  1  1=store, 0=load
dm_be  in  DATA_W/8  store byte enables
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data accepted this cycle
dm_rvalid  out  1  load data / store ack (1 cycle)
dm_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe (1 cycle)
mem_we  out  1  memory write
mem_be  out  DATA_W/8  memory byte enables
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, counter=0, owner=none. All outputs 0, including mem_* registers, gnt, rvalid, rdata and busy.
- States:
  - IDLE: no access in flight.
  - ISSUE: mem_en cycle.
  - WAIT: counting down MEM_LAT.
- IDLE, cycle T:
  - If dm_req, dm_gnt=1 combinationally; else if if_req, if_gnt=1. dm wins ties.
  - At the T edge, the winner's addr/we/be/wdata are registered into mem_* and owner is recorded. Fetch forces we=0 and be=all-ones. State goes to ISSUE.
- ISSUE, cycle T+1: mem_en=1 with the registered fields. Counter loads MEM_LAT; state goes to WAIT.
- WAIT: counter decrements each cycle. In cycle T+1+MEM_LAT (counter==1):
  - Owner's rvalid=1 and owner's rdata=mem_rdata combinationally.
  - Store: dm_rvalid=1 as ack with dm_rdata=0.
  - State goes to IDLE at that edge.
- rdata outputs are 0 whenever the matching rvalid is 0.
- mem_en, mem_we and mem_wdata are 0 outside ISSUE. mem_addr/mem_be hold their last value.
- Throughput: one transaction per MEM_LAT+2 cycles. Next grant is no earlier than T+MEM_LAT+2.
- Requests in ISSUE/WAIT: gnt stays 0 and requests are not queued. Requesters hold req and fields stable.
- Dropping req before gnt is legal; no transaction occurs.
- Reset mid-transaction: the in-flight access is abandoned. No rvalid is produced, even if mem_rdata arrives later.
- gnt and rvalid are never asserted to both ports in the same cycle. A port never sees gnt and rvalid in the same cycle.

Optional Feature:
ARB_STARVE_GUARD_EN:
- Defined:
  - A 4-bit starve counter counts dm grants issued while if_req=1.
  - When starve==STARVE_MAX and both requests are present in IDLE, the fetch port wins.
  - starve clears on any if grant or when if_req=0. It resets to 0.
- Undefined: strict data priority; counter is absent. Fetch can starve indefinitely while dm_req is held.

Test Plan:
1. Single fetch (MEM_LAT=2):
   - Stimulus: if_req, if_addr=0x10 at T; memory returns 0x00500093.
   - Response: if_gnt at T; mem_en=1, mem_addr=0x10, mem_we=0 at T+1; if_rvalid=1, if_rdata=0x00500093 at T+3; busy T+1..T+3.
2. Store:
   - Stimulus: dm_we=1, dm_be=0xF, dm_addr=0x100, dm_wdata=0xDEADBEEF at T.
   - Response: mem_en=mem_we=1, mem_wdata=0xDEADBEEF at T+1; dm_rvalid=1, dm_rdata=0 at T+3.
3. Simultaneous requests at T:
   - Response: dm_gnt at T and dm_rvalid at T+3; if_gnt at T+4 and if_rvalid at T+7.
4. Request during WAIT:
   - Stimulus: if_req rises at T+1 during a dm access.
   - Response: if_gnt=0 for T+1..T+3; if_gnt=1 at T+4.
5. Reset mid-operation:
   - Stimulus: reset low at T+2 of a load.
   - Response: all outputs 0 immediately; no dm_rvalid.
   - After release, a fresh fetch completes normally per scenario 1.
6. Starvation, dm_req and if_req held high continuously:
   - With ARB_STARVE_GUARD_EN, STARVE_MAX=4: grants are dm,dm,dm,dm,if, then dm resumes.
   - Without the macro: if_gnt stays 0 for 10 transactions.
